// File: rtl/irq_sequencer_if.sv
// Signal bundle between the interrupt sequencer and the core/register file.
// The master side is the core and register file; the slave side is the sequencer.
interface irq_sequencer_if #(
  parameter int CAUSE_W = 8
);
  logic               i_irq;
  logic               i_irq_en;
  logic [CAUSE_W-1:0] i_cause;
  logic               i_core_pc_en;
  logic               i_ret;
  logic [31:0]        i_ret_addr;
  logic               o_int_mode;
  logic [1:0]         o_irq_bak;
  logic [31:0]        o_irq_r0;
  logic [31:0]        o_irq_r1;
  logic               o_pc_en;
  logic [31:0]        o_pc_reg;
  logic               o_flush;
  logic               o_busy;

  modport master (
    output i_irq, i_irq_en, i_cause, i_core_pc_en, i_ret, i_ret_addr,
    input  o_int_mode, o_irq_bak, o_irq_r0, o_irq_r1, o_pc_en, o_pc_reg, o_flush, o_busy
  );

  modport slave (
    input  i_irq, i_irq_en, i_cause, i_core_pc_en, i_ret, i_ret_addr,
    output o_int_mode, o_irq_bak, o_irq_r0, o_irq_r1, o_pc_en, o_pc_reg, o_flush, o_busy
  );
endinterface

// File: rtl/irq_sequencer.sv
// Interrupt entry/exit sequencer for the banked register file.
// Walks SAVE -> LINK -> ENTER -> ACTIVE -> EXIT and redirects the PC on entry and exit.
module irq_sequencer #(
  parameter logic [31:0] VECTOR  = 32'h0000_0018,
  parameter int          CAUSE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  irq_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAVE   = 3'd1,
    LINK   = 3'd2,
    ENTER  = 3'd3,
    ACTIVE = 3'd4,
    EXIT   = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic               pending;
  logic [CAUSE_W-1:0] cause_q;
  logic [15:0]        count;
  logic [31:0]        ret_q;
  logic               accept;
  logic               ret_take;

  assign accept   = (state == IDLE) && en && bus.i_irq_en && (pending || bus.i_irq);
  assign ret_take = (state == ACTIVE) && en && bus.i_ret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)   state_nxt = SAVE;
      SAVE:    if (en)       state_nxt = LINK;
      LINK:    if (en)       state_nxt = ENTER;
      ENTER:   if (en)       state_nxt = ACTIVE;
      ACTIVE:  if (ret_take) state_nxt = EXIT;
      EXIT:    if (en)       state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Requests are latched regardless of en/state so none are lost during a sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      cause_q <= '0;
      count   <= '0;
      ret_q   <= '0;
    end else begin
      pending <= accept ? 1'b0 : (pending | bus.i_irq);
      if (accept) begin
        cause_q <= bus.i_cause;
        count   <= count + 16'd1;
      end
      if (ret_take) ret_q <= bus.i_ret_addr;
    end
  end

  always_comb begin
    bus.o_int_mode = 1'b0;
    bus.o_irq_bak  = 2'b00;
    bus.o_pc_en    = 1'b0;
    bus.o_flush    = 1'b0;
    bus.o_pc_reg   = 32'h0;
    bus.o_busy     = (state != IDLE);
    unique case (state)
      IDLE, SAVE: ;
      // Banked r14 takes the in-flight branch target when the pipeline is writing PC.
      LINK:   bus.o_irq_bak = bus.i_core_pc_en ? 2'b11 : 2'b10;
      ENTER: begin
        bus.o_int_mode = 1'b1;
        bus.o_irq_bak  = 2'b10;
        bus.o_pc_en    = en;
        bus.o_flush    = en;
        bus.o_pc_reg   = VECTOR;
      end
      ACTIVE: begin
        bus.o_int_mode = 1'b1;
        bus.o_irq_bak  = 2'b10;
      end
      EXIT: begin
        bus.o_pc_en  = en;
        bus.o_flush  = en;
        bus.o_pc_reg = ret_q;
      end
      default: ;
    endcase
  end

  assign bus.o_irq_r0 = {{(32-CAUSE_W){1'b0}}, cause_q};
  assign bus.o_irq_r1 = {16'h0, count};

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: entry/exit sequence, en stalls, re-entry, masking, async reset.
module tb_irq_sequencer;
  logic clk;
  logic rst_n;
  logic en;
  int   total = 0;
  int   bad   = 0;

  irq_sequencer_if #(.CAUSE_W(8)) bus ();

  irq_sequencer #(.VECTOR(32'h0000_0018), .CAUSE_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    bus.i_irq = 1'b0;
    bus.i_irq_en = 1'b1;
    bus.i_cause = 8'h00;
    bus.i_core_pc_en = 1'b0;
    bus.i_ret = 1'b0;
    bus.i_ret_addr = 32'h0;
    tick(); tick();
    chk("rst_int_mode", {31'h0, bus.o_int_mode}, 32'h0);
    chk("rst_bak", {30'h0, bus.o_irq_bak}, 32'h0);
    chk("rst_pc_en", {31'h0, bus.o_pc_en}, 32'h0);
    chk("rst_flush", {31'h0, bus.o_flush}, 32'h0);
    chk("rst_busy", {31'h0, bus.o_busy}, 32'h0);
    chk("rst_pc_reg", bus.o_pc_reg, 32'h0);
    chk("rst_r0", bus.o_irq_r0, 32'h0);
    chk("rst_r1", bus.o_irq_r1, 32'h0);
    rst_n = 1'b1;

    // First entry: cause 5
    bus.i_irq = 1'b1; bus.i_cause = 8'h05;
    tick();
    bus.i_irq = 1'b0;
    chk("save_busy", {31'h0, bus.o_busy}, 32'h1);
    chk("save_bak", {30'h0, bus.o_irq_bak}, 32'h0);
    chk("save_mode", {31'h0, bus.o_int_mode}, 32'h0);
    chk("save_r0", bus.o_irq_r0, 32'h5);
    chk("save_r1", bus.o_irq_r1, 32'h1);
    tick();
    chk("link_bak", {30'h0, bus.o_irq_bak}, 32'h2);
    chk("link_pc_en", {31'h0, bus.o_pc_en}, 32'h0);
    tick();
    chk("enter_pc_en", {31'h0, bus.o_pc_en}, 32'h1);
    chk("enter_flush", {31'h0, bus.o_flush}, 32'h1);
    chk("enter_pc_reg", bus.o_pc_reg, 32'h18);
    chk("enter_mode", {31'h0, bus.o_int_mode}, 32'h1);
    tick();
    chk("active_mode", {31'h0, bus.o_int_mode}, 32'h1);
    chk("active_pc_en", {31'h0, bus.o_pc_en}, 32'h0);
    chk("active_bak", {30'h0, bus.o_irq_bak}, 32'h2);
    tick();
    chk("active_hold", {31'h0, bus.o_int_mode}, 32'h1);

    // Return
    bus.i_ret = 1'b1; bus.i_ret_addr = 32'h0000_1234;
    tick();
    bus.i_ret = 1'b0;
    chk("exit_pc_en", {31'h0, bus.o_pc_en}, 32'h1);
    chk("exit_flush", {31'h0, bus.o_flush}, 32'h1);
    chk("exit_pc_reg", bus.o_pc_reg, 32'h1234);
    chk("exit_mode", {31'h0, bus.o_int_mode}, 32'h0);
    tick();
    chk("idle_busy", {31'h0, bus.o_busy}, 32'h0);
    chk("idle_pc_en", {31'h0, bus.o_pc_en}, 32'h0);
    chk("idle_r0_held", bus.o_irq_r0, 32'h5);

    // Second entry: in-flight PC write during LINK, en stall
    bus.i_irq = 1'b1; bus.i_cause = 8'h0A;
    tick();
    bus.i_irq = 1'b0;
    chk("save2_r0", bus.o_irq_r0, 32'hA);
    chk("save2_r1", bus.o_irq_r1, 32'h2);
    tick();
    bus.i_core_pc_en = 1'b1;
    #1;
    chk("link2_bak", {30'h0, bus.o_irq_bak}, 32'h3);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_bak", {30'h0, bus.o_irq_bak}, 32'h3);
      chk("stall_pc_en", {31'h0, bus.o_pc_en}, 32'h0);
      chk("stall_mode", {31'h0, bus.o_int_mode}, 32'h0);
    end
    en = 1'b1;
    tick();
    bus.i_core_pc_en = 1'b0;
    chk("enter2_pc_en", {31'h0, bus.o_pc_en}, 32'h1);
    chk("enter2_pc_reg", bus.o_pc_reg, 32'h18);
    en = 1'b0;
    #1;
    chk("enter2_gated", {31'h0, bus.o_pc_en}, 32'h0);
    chk("enter2_flush_gated", {31'h0, bus.o_flush}, 32'h0);
    en = 1'b1;
    tick();
    chk("active2_mode", {31'h0, bus.o_int_mode}, 32'h1);

    // Request during ACTIVE is held and re-enters after exit
    bus.i_irq = 1'b1; bus.i_cause = 8'h33;
    tick();
    bus.i_irq = 1'b0;
    chk("nest_blocked", {31'h0, bus.o_int_mode}, 32'h1);
    chk("nest_r1", bus.o_irq_r1, 32'h2);
    bus.i_ret = 1'b1; bus.i_ret_addr = 32'h0000_0040;
    tick();
    bus.i_ret = 1'b0;
    chk("exit2_pc_reg", bus.o_pc_reg, 32'h40);
    chk("exit2_pc_en", {31'h0, bus.o_pc_en}, 32'h1);
    tick();
    chk("idle2_busy", {31'h0, bus.o_busy}, 32'h0);
    tick();
    chk("reenter_busy", {31'h0, bus.o_busy}, 32'h1);
    chk("reenter_r1", bus.o_irq_r1, 32'h3);
    chk("reenter_r0", bus.o_irq_r0, 32'h33);
    tick(); tick(); tick();
    bus.i_ret = 1'b1; bus.i_ret_addr = 32'h0000_0100;
    tick();
    bus.i_ret = 1'b0;
    chk("exit3_pc_reg", bus.o_pc_reg, 32'h100);
    tick();
    chk("idle3_busy", {31'h0, bus.o_busy}, 32'h0);

    // Masked request: held until enabled; i_ret in IDLE ignored
    bus.i_irq_en = 1'b0; bus.i_irq = 1'b1; bus.i_cause = 8'h77;
    tick();
    bus.i_irq = 1'b0;
    tick();
    chk("masked_busy", {31'h0, bus.o_busy}, 32'h0);
    bus.i_ret = 1'b1;
    tick();
    bus.i_ret = 1'b0;
    chk("ret_idle_pc_en", {31'h0, bus.o_pc_en}, 32'h0);
    chk("ret_idle_busy", {31'h0, bus.o_busy}, 32'h0);
    bus.i_irq_en = 1'b1;
    tick();
    chk("unmask_busy", {31'h0, bus.o_busy}, 32'h1);
    chk("unmask_r1", bus.o_irq_r1, 32'h4);
    chk("unmask_r0", bus.o_irq_r0, 32'h77);

    // Async reset in ENTER with a request pending
    bus.i_irq = 1'b1;
    tick();
    bus.i_irq = 1'b0;
    tick();
    chk("pre_rst_pc_en", {31'h0, bus.o_pc_en}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mode", {31'h0, bus.o_int_mode}, 32'h0);
    chk("arst_pc_en", {31'h0, bus.o_pc_en}, 32'h0);
    chk("arst_busy", {31'h0, bus.o_busy}, 32'h0);
    chk("arst_r1", bus.o_irq_r1, 32'h0);
    #2 rst_n = 1'b1;
    tick(); tick();
    chk("pending_cleared", {31'h0, bus.o_busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
